lcd_num_formatter: RTL

Parametrised binary-to-LCD-character formatter for the clock display path. Accepts an unsigned binary value and converts it iteratively to BCD using shift-and-add-3. It then streams one 8-bit HD44780 character code per digit, most significant digit first, over a valid/ready handshake to the LCD write sequencer. The block supports configurable digit count, optional leading-zero blanking and overflow indication, so any field (hours, minutes, seconds, counters) comes from one instance type.

---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_num_formatter_bcd_adj3.sv | 12 +
 rtl/lcd_num_formatter.sv | 109 ++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD number formatter.
package lcd_pkg;

   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_OVF   = 8'h23;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      EMIT = 2'd2
   } state_t;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return CH_ZERO | {4'h0, d};
   endfunction

endpackage

// File: rtl/lcd_num_formatter_bcd_adj3.sv
// Shift-and-add-3 correction cell: one BCD nibble, adds 3 when the nibble is 5 or more.
module bcd_adj3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) dout = din + 4'd3;
   end

endmodule

// File: rtl/lcd_num_formatter.sv
// Binary to BCD (shift-and-add-3) converter that streams one HD44780 character
// per digit, most significant first, over a valid/ready handshake.
module lcd_num_formatter #(
   parameter int BIN_W    = 16,
   parameter int DIGITS   = 5,
   parameter int BLANK_LZ = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             char_valid,
   input  logic             char_ready,
   output logic [7:0]       char_data,
   output logic             char_last,
   output logic             overflow
);
   import lcd_pkg::*;

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t             state, state_n;
   logic [BIN_W-1:0]   bin_sr;
   logic [BCD_W-1:0]   bcd;
   logic [BCD_W-1:0]   adj;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic               ovf_q;
   logic               blank_q;
   logic [3:0]         digit;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adj3 u_adj (
         .din  (bcd[4*g +: 4]),
         .dout (adj[4*g +: 4])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = CONV;
         CONV:    if (cnt == '0) state_n = EMIT;
         EMIT:    if (char_ready && idx == '0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_sr  <= '0;
         bcd     <= '0;
         cnt     <= '0;
         idx     <= '0;
         ovf_q   <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               bin_sr  <= bin;
               bcd     <= '0;
               cnt     <= CNT_W'(BIN_W);
               ovf_q   <= 1'b0;
               blank_q <= (BLANK_LZ != 0);
            end
            CONV: if (cnt != '0) begin
               // carry out of the top nibble means the value needs more digits
               {bcd, bin_sr} <= {adj[BCD_W-2:0], bin_sr, 1'b0};
               if (adj[BCD_W-1]) ovf_q <= 1'b1;
               cnt <= cnt - 1'b1;
            end else begin
               idx <= IDX_W'(DIGITS - 1);
            end
            EMIT: if (char_ready) begin
               if (digit != 4'd0) blank_q <= 1'b0;
               if (idx != '0) idx <= idx - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // outputs decode only registered state, so char_ready never reaches char_valid
   always_comb begin
      digit      = bcd[4*idx +: 4];
      busy       = (state != IDLE);
      char_valid = (state == EMIT);
      char_last  = (state == EMIT) && (idx == '0);
      overflow   = ovf_q;
      char_data  = 8'h00;
      if (state == EMIT) begin
         if (ovf_q)
            char_data = CH_OVF;
         else if (blank_q && digit == 4'd0 && idx != '0)
            char_data = CH_SPACE;
         else
            char_data = digit_char(digit);
      end
   end

endmodule
